// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the ARM7TDMI front end.
// Fetch FSM encoding, instruction sizes and the prefetch entry layout live here.
package arm7tdmi_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_DRAIN
    } fetch_state_t;

    localparam int ARM_INSTR_BYTES   = 4;
    localparam int THUMB_INSTR_BYTES = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        thumb;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Thumb code lives in halfwords; pc[1] picks which half of the fetched word.
    function automatic logic [31:0] thumb_halfword(input logic [31:0] word, input logic sel_hi);
        return sel_hi ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
    endfunction

endpackage

// File: rtl/arm7tdmi_prefetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc, thumb} entries ahead of decode.
// Head is read combinationally; clear has priority over push and pop.
module arm7tdmi_prefetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !i_clear;
    assign w_pop   = i_pop && !i_clear && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == AW'(gi))) begin
                    r_mem[gi] <= i_data;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/arm7tdmi_fetch.sv
// Instruction fetch stage: single-outstanding word reads into a prefetch FIFO,
// branch redirect with drain of an in-flight read, and Thumb halfword extraction.
module arm7tdmi_fetch
    import arm7tdmi_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        branch_thumb,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        thumb_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic         r_thumb;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_after;
    logic          w_space;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_pc_inc;
    logic [31:0]   w_branch_pc;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    assign w_pop  = instr_valid && !stall;
    assign w_push = (r_state == F_REQ) && imem_ack && !branch_taken;

    // Space is judged after this cycle's pop and push so the FIFO can never overflow.
    assign w_count_after = w_count - CW'(w_pop) + CW'(w_push);
    assign w_space       = w_count_after < CW'(FIFO_DEPTH);

    assign w_pc_inc    = r_fetch_pc + (r_thumb ? 32'(THUMB_INSTR_BYTES) : 32'(ARM_INSTR_BYTES));
    assign w_branch_pc = branch_target & (branch_thumb ? ~32'h1 : ~32'h3);

    assign w_push_entry.instr = r_thumb ? thumb_halfword(imem_rdata, r_fetch_pc[1]) : imem_rdata;
    assign w_push_entry.pc    = r_fetch_pc;
    assign w_push_entry.thumb = r_thumb;

    arm7tdmi_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FETCH_ENTRY_W),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_clear (branch_taken),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign instr_valid = (w_count != '0);
    assign instruction = w_head.instr;
    assign pc_out      = w_head.pc;
    assign thumb_out   = w_head.thumb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= F_IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_VECTOR & ~32'h3;
            r_fetch_pc <= RESET_VECTOR;
            r_thumb    <= 1'b0;
        end else if (branch_taken) begin
            r_fetch_pc <= w_branch_pc;
            r_thumb    <= branch_thumb;
            // A read still in flight must complete before the target can be requested.
            if (r_state != F_IDLE && !imem_ack) begin
                r_state <= F_DRAIN;
            end else begin
                r_state   <= F_REQ;
                imem_req  <= 1'b1;
                imem_addr <= w_branch_pc & ~32'h3;
            end
        end else begin
            case (r_state)
                F_IDLE: begin
                    if (w_space) begin
                        r_state   <= F_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= r_fetch_pc & ~32'h3;
                    end
                end
                F_REQ: begin
                    if (imem_ack) begin
                        r_fetch_pc <= w_pc_inc;
                        if (w_space) begin
                            imem_addr <= w_pc_inc & ~32'h3;
                        end else begin
                            r_state  <= F_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                F_DRAIN: begin
                    // Stale data is dropped; the FIFO is empty, so re-issue at once.
                    if (imem_ack) begin
                        r_state   <= F_REQ;
                        imem_addr <= r_fetch_pc & ~32'h3;
                    end
                end
                default: begin
                    r_state  <= F_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
